memref_host_responder: RTL and testbench

MEMREF_HOST_RESPONDER -- requirements
Module: memref_host_responder

---
 rtl/memref_pkg.sv | 17 +
 rtl/memref_bank.sv | 36 +++
 rtl/memref_host_responder.sv | 168 ++++++++++++++++
 tb/tb_memref_host_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/memref_pkg.sv
// Shared defaults and FSM state type for the memref host responder.
package memref_pkg;

    localparam int unsigned DefWidth    = 32;
    localparam int unsigned DefSize     = 256;
    localparam int unsigned DefAddrW    = 8;
    localparam int unsigned DefExpectWr = 256;

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/memref_bank.sv
// Single-bank word memory: one synchronous write port, one registered read port.
module memref_bank
    import memref_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned SIZE   = DefSize,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/memref_host_responder.sv
// Host-side responder: loads bank A from the host, lets a kernel read A / write C,
// then drains C back to the host over a valid/ready stream.
module memref_host_responder
    import memref_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned SIZE      = DefSize,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned EXPECT_WR = DefExpectWr
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              t,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              done,
    output logic              err
);

    localparam int unsigned CntW = ADDR_W + 1;

    state_e state_q, state_d;

    logic [CntW-1:0]  load_cnt_q, wr_cnt_q, rd_ptr_q, out_cnt_q;
    logic             in_ready_q, err_q;
    logic             pend_q, skid_valid_q, out_valid_q;
    logic [WIDTH-1:0] skid_data_q, out_data_q, c_rd_data;
    logic             load_act, run_act, drain_act;
    logic             load_fire, kern_rd, kern_wr, drain_rd, out_fire;

    assign load_fire = load_act & in_valid & in_ready_q;
    assign kern_rd   = run_act & rd_en & rst;
    assign kern_wr   = run_act & wr_en & rst;
    assign out_fire  = out_valid_q & out_ready;

    // Issue a prefetch only if the word returning next cycle is sure to find a slot.
    assign drain_rd = drain_act & rst & (rd_ptr_q != CntW'(SIZE)) & ~skid_valid_q
                    & ~(pend_q & out_valid_q & ~out_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (load_fire && load_cnt_q == CntW'(SIZE - 1)) state_d = StStart;
            StStart: state_d = StRun;
            StRun:   if (kern_wr && wr_cnt_q == CntW'(EXPECT_WR - 1)) state_d = StDrain;
            StDrain: if (out_fire && out_cnt_q == CntW'(SIZE - 1)) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        t         = 1'b0;
        done      = 1'b0;
        load_act  = 1'b0;
        run_act   = 1'b0;
        drain_act = 1'b0;
        unique case (state_q)
            StLoad:  load_act  = 1'b1;
            StStart: t         = 1'b1;
            StRun:   run_act   = 1'b1;
            StDrain: drain_act = 1'b1;
            StDone:  done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            load_cnt_q <= '0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            out_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (load_fire) load_cnt_q <= load_cnt_q + 1'b1;
            if (kern_wr)   wr_cnt_q   <= wr_cnt_q + 1'b1;
            if (drain_rd)  rd_ptr_q   <= rd_ptr_q + 1'b1;
            if (out_fire)  out_cnt_q  <= out_cnt_q + 1'b1;
            in_ready_q <= (state_d == StLoad);
            if ((rd_en || wr_en) && state_q != StRun) err_q <= 1'b1;
        end
    end

    // Output register plus one skid entry absorb the bank read latency under stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            pend_q <= drain_rd;
            if (!out_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    skid_valid_q <= pend_q;
                    if (pend_q) skid_data_q <= c_rd_data;
                end else if (pend_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= c_rd_data;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= c_rd_data;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

    memref_bank #(
        .WIDTH  (WIDTH),
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load_fire),
        .wr_addr (load_cnt_q[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_en   (kern_rd),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    memref_bank #(
        .WIDTH  (WIDTH),
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_bank_c (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (kern_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (drain_rd),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (c_rd_data)
    );

endmodule

// File: tb/tb_memref_host_responder.sv
// Directed bench: three load/run passes covering reset, transpose drain and stalled drain.
module tb_memref_host_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        t;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memref_host_responder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .t         (t),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold in_valid high until 256 words are accepted; optional strays during LOAD.
    task automatic load_all(input bit stray_wr, input bit stray_rd);
        int acc = 0;
        int cyc = 0;
        int t_seen = 0;
        bit fire;
        while (acc < 256 && cyc < 600) begin
            in_valid = 1'b1;
            in_data  = 32'(acc);
            wr_en    = stray_wr && (cyc == 10);
            wr_addr  = 8'd3;
            wr_data  = 32'hDEAD;
            rd_en    = stray_rd && (cyc == 12);
            rd_addr  = 8'd7;
            fire     = in_ready;
            if (t) t_seen++;
            tick();
            cyc++;
            if (fire) acc++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("load_accepts", 32'(acc), 32'd256);
        chk("no_t_during_load", 32'(t_seen), 32'd0);
        chk("t_after_last_accept", 32'(t), 32'd1);
        chk("in_ready_in_start", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t_single_pulse", 32'(t), 32'd0);
    endtask

    task automatic kwrite(input logic [7:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [31:0] exp_c(input int run, input int j);
        if (run == 2) return 32'((j % 16) * 16 + j / 16);
        if (j == 3) return 32'h30;
        return 32'(j + 'h100);
    endfunction

    task automatic drain(input int run, input bit toggle);
        logic [3:0]  pat = 4'b1001;
        logic [31:0] prev_data = '0;
        bit          prev_stall = 1'b0;
        int          idx = 0;
        int          cyc = 0;
        while (idx < 256 && cyc < 3000) begin
            out_ready = toggle ? pat[cyc % 4] : 1'b1;
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(out_valid), 32'd1);
                chk("stall_data_hold", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("drain_word[%0d]", idx), out_data, exp_c(run, idx));
                idx++;
            end
            if (idx < 256) chk("done_low_in_drain", 32'(done), 32'd0);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            tick();
            cyc++;
        end
        chk("drain_word_count", 32'(idx), 32'd256);
        chk("done_after_drain", 32'(done), 32'd1);
        chk("out_valid_after_drain", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_t", 32'(t), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b1;
        chk("in_ready_before_first_edge", 32'(in_ready), 32'd0);
        tick();
        chk("in_ready_after_release", 32'(in_ready), 32'd1);

        // Pass 1: stray read during LOAD, then reset mid-RUN after 100 writes.
        load_all(1'b0, 1'b1);
        chk("stray_rd_err", 32'(err), 32'd1);
        chk("stray_rd_no_data", rd_data, 32'd0);
        rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        chk("rd_a5", rd_data, 32'd5);
        rd_en = 1'b0; rd_addr = 8'h09;
        tick();
        chk("rd_hold", rd_data, 32'd5);
        for (int i = 0; i < 100; i++) begin
            rd_en   = (i == 1);
            rd_addr = 8'd16;
            kwrite(8'((i % 16) * 16 + i / 16), 32'(i));
            rd_en = 1'b0;
            if (i == 1) chk("rd_wr_collision", rd_data, 32'd16);
        end
        rst = 1'b0;
        tick();
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd0);
        chk("midrun_rst_t", 32'(t), 32'd0);
        chk("midrun_rst_err", 32'(err), 32'd0);
        chk("midrun_rst_done", 32'(done), 32'd0);
        chk("midrun_rst_rd_data", rd_data, 32'd0);
        rst = 1'b1;
        tick();
        chk("midrun_rst_t_after", 32'(t), 32'd0);
        chk("midrun_reload_ready", 32'(in_ready), 32'd1);

        // Pass 2: full transpose and free-running drain.
        load_all(1'b0, 1'b0);
        chk("in_valid_outside_load_no_err", 32'(err), 32'd0);
        for (int i = 0; i < 255; i++) kwrite(8'((i % 16) * 16 + i / 16), 32'(i));
        tick();
        chk("no_drain_before_last_wr", 32'(out_valid), 32'd0);
        chk("not_done_before_last_wr", 32'(done), 32'd0);
        kwrite(8'hFF, 32'd255);
        drain(2, 1'b0);

        rst = 1'b0;
        tick();
        chk("rst_clears_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();

        // Pass 3: stray write to C[3] during LOAD, repeated writes, stalled drain.
        load_all(1'b1, 1'b0);
        chk("stray_wr_err", 32'(err), 32'd1);
        kwrite(8'd0, 32'hBAD);
        for (int j = 0; j < 256; j++) begin
            if (j != 3) kwrite(8'(j), 32'(j + 'h100));
        end
        drain(3, 1'b1);
        chk("err_sticky", 32'(err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
